// File: rtl/ode_pkg.sv
// Shared definitions for the Euler ODE accelerator datapath: FSM encoding,
// fixed-point constants and the signed saturation helper.
package ode_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned FRAC_BITS_DEF = 8;
  localparam int unsigned FIXED_ONE     = 1 << FRAC_BITS_DEF;
  localparam int unsigned SAT_W         = 64;

  // Clamp v to the signed range of a w-bit word; result is still SAT_W wide.
  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                         input int unsigned w);
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (SAT_W'(1) << (w - 1)) - SAT_W'(1);
    min_v = -max_v - SAT_W'(1);
    if (v > max_v) begin
      return max_v;
    end else if (v < min_v) begin
      return min_v;
    end
    return v;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed fixed-point multiply-accumulate for one matrix row, with a registered,
// shifted and saturated row result.
module mac_unit
  import ode_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned ACC_SIZE  = 35
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 valid,
  input  logic                 first,
  input  logic                 last,
  input  logic [DATA_SIZE-1:0] data_mat,
  input  logic [DATA_SIZE-1:0] data_vec,
  output logic [DATA_SIZE-1:0] row_result,
  output logic                 row_valid
);

  logic signed [2*DATA_SIZE-1:0] prod;
  logic signed [ACC_SIZE-1:0]    prod_ext;
  logic signed [ACC_SIZE-1:0]    acc_q, acc_d;
  logic signed [ACC_SIZE-1:0]    shifted;
  logic signed [SAT_W-1:0]       wide;
  logic [DATA_SIZE-1:0]          row_result_q;
  logic                          row_valid_q;

  always_comb begin
    prod     = $signed(data_mat) * $signed(data_vec);
    prod_ext = {{(ACC_SIZE-2*DATA_SIZE){prod[2*DATA_SIZE-1]}}, prod};
    acc_d    = first ? prod_ext : acc_q + prod_ext;
    // Saturation works on the row total including the column arriving this cycle.
    shifted  = acc_d >>> FRAC_BITS;
    wide     = {{(SAT_W-ACC_SIZE){shifted[ACC_SIZE-1]}}, shifted};
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      acc_q <= '0;
    end else if (valid) begin
      acc_q <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_result_q <= '0;
      row_valid_q  <= 1'b0;
    end else begin
      row_valid_q <= valid && last;
      if (valid && last) begin
        row_result_q <= DATA_SIZE'(sat_signed(wide, DATA_SIZE));
      end
    end
  end

  assign row_result = row_result_q;
  assign row_valid  = row_valid_q;

endmodule

// File: rtl/mac_row_stage.sv
// Execute stage: drives the fetch controls, tracks the 1-cycle RAM read latency
// and produces one saturated dot product per matrix row.
module mac_row_stage
  import ode_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned COLS      = 5,
  parameter int unsigned ROWS      = 5,
  parameter int unsigned ACC_SIZE  = 2 * DATA_SIZE + $clog2(COLS + 1),
  localparam int unsigned COL_W    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int unsigned ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic [DATA_SIZE-1:0] data_mat,
  input  logic [DATA_SIZE-1:0] data_vec,
  output logic                 init_start,
  output logic                 fetch_enable,
  output logic                 finished_one_row,
  output logic                 final_done,
  output logic [DATA_SIZE-1:0] row_result,
  output logic [ROW_W-1:0]     row_index,
  output logic                 row_valid,
  output logic                 busy,
  output logic                 done
);

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic             issue, last_col, last_row;

  // Issue pipeline: one stage matching the RAM read latency.
  logic             iss_q, iss_first_q, iss_last_q;
  logic [ROW_W-1:0] iss_row_q;
  logic [ROW_W-1:0] row_idx_q;

  assign issue    = (state_q == StRun) && !stall;
  assign last_col = (col_q == COL_W'(COLS - 1));
  assign last_row = (row_q == ROW_W'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StRun;
      StRun:   if (issue && last_col && last_row) state_d = StDrain;
      // Earlier rows can still be completing here; wait for the final one.
      StDrain: if (row_valid && row_index == ROW_W'(ROWS - 1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    init_start       = (state_q == StLoad);
    fetch_enable     = issue;
    finished_one_row = issue && last_col;
    final_done       = issue && last_col && last_row;
    busy             = (state_q != StIdle);
    done             = (state_q == StDone);
  end

  always_ff @(posedge clk) begin
    if (!reset || state_q == StLoad) begin
      col_q <= '0;
      row_q <= '0;
    end else if (issue) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      iss_q       <= 1'b0;
      iss_first_q <= 1'b0;
      iss_last_q  <= 1'b0;
      iss_row_q   <= '0;
      row_idx_q   <= '0;
    end else begin
      iss_q       <= issue;
      iss_first_q <= (col_q == '0);
      iss_last_q  <= last_col;
      iss_row_q   <= row_q;
      if (iss_q && iss_last_q) begin
        row_idx_q <= iss_row_q;
      end
    end
  end

  assign row_index = row_idx_q;

  mac_unit #(
    .DATA_SIZE(DATA_SIZE),
    .FRAC_BITS(FRAC_BITS),
    .ACC_SIZE (ACC_SIZE)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q == StLoad),
    .valid     (iss_q),
    .first     (iss_first_q),
    .last      (iss_last_q),
    .data_mat  (data_mat),
    .data_vec  (data_vec),
    .row_result(row_result),
    .row_valid (row_valid)
  );

endmodule

// File: tb/tb_mac_row_stage.sv
// Directed bench: a 2x2 instance and a 1x1 instance, each fed by a small fetch/RAM model.
`timescale 1ns/1ps
module tb_mac_row_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: COLS=2, ROWS=2
  logic        rst_a, start_a, stall_a;
  logic [15:0] mat_a, vec_a, res_a;
  logic        init_a, fe_a, fro_a, fd_a, idx_a, rv_a, busy_a, done_a;
  // Instance B: COLS=1, ROWS=1
  logic        rst_b, start_b, stall_b;
  logic [15:0] mat_b, vec_b, res_b;
  logic        init_b, fe_b, fro_b, fd_b, idx_b, rv_b, busy_b, done_b;

  mac_row_stage #(.DATA_SIZE(16), .FRAC_BITS(8), .COLS(2), .ROWS(2)) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .stall(stall_a),
    .data_mat(mat_a), .data_vec(vec_a),
    .init_start(init_a), .fetch_enable(fe_a), .finished_one_row(fro_a), .final_done(fd_a),
    .row_result(res_a), .row_index(idx_a), .row_valid(rv_a), .busy(busy_a), .done(done_a)
  );

  mac_row_stage #(.DATA_SIZE(16), .FRAC_BITS(8), .COLS(1), .ROWS(1)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .stall(stall_b),
    .data_mat(mat_b), .data_vec(vec_b),
    .init_start(init_b), .fetch_enable(fe_b), .finished_one_row(fro_b), .final_done(fd_b),
    .row_result(res_b), .row_index(idx_b), .row_valid(rv_b), .busy(busy_b), .done(done_b)
  );

  // Fetch/RAM model for A: two PCs, one-cycle read latency, garbage when not reading.
  logic [15:0] a_mat_mem [0:3];
  logic [15:0] a_vec_mem [0:1];
  logic [1:0]  a_mpc;
  logic        a_vpc;
  always @(posedge clk) begin
    if (fe_a) begin
      mat_a <= a_mat_mem[a_mpc];
      vec_a <= a_vec_mem[a_vpc];
    end else begin
      mat_a <= 16'hDEAD;
      vec_a <= 16'hBEEF;
    end
    if (init_a || fd_a) begin
      a_mpc <= 2'd0;
      a_vpc <= 1'b0;
    end else if (fe_a) begin
      a_mpc <= a_mpc + 2'd1;
      a_vpc <= fro_a ? 1'b0 : a_vpc + 1'b1;
    end
  end

  logic [15:0] b_mat_val, b_vec_val;
  always @(posedge clk) begin
    if (fe_b) begin
      mat_b <= b_mat_val;
      vec_b <= b_vec_val;
    end else begin
      mat_b <= 16'hA5A5;
      vec_b <= 16'h5A5A;
    end
  end

  int errors = 0;
  int checks = 0;

  int          n_fe, n_fro, n_fd, n_rv, n_done, n_viol, n_late;
  int          t_init, t_last, t_done, t_idle, n_both;
  int          t_rv [0:1];
  logic [15:0] rv_val [0:1];
  logic        rv_idx [0:1];

  // One full pass on A; start_again re-pulses start at that cycle (-1 = never).
  task automatic run_pass_a(input bit do_stall, input int start_again);
    n_fe = 0; n_fro = 0; n_fd = 0; n_rv = 0; n_done = 0; n_viol = 0; n_late = 0;
    t_init = -1; t_last = -1; t_done = -1; t_idle = -1;
    t_rv[0] = -1; t_rv[1] = -1; rv_val[0] = 'x; rv_val[1] = 'x; rv_idx[0] = 'x; rv_idx[1] = 'x;
    for (int i = 0; i < 40 && t_idle < 0; i++) begin
      @(negedge clk);
      start_a = (i == 0) || (i == start_again);
      stall_a = do_stall ? i[0] : 1'b0;
      #1;
      if (init_a) t_init = i;
      if (fe_a) n_fe++;
      if (fe_a && stall_a) n_viol++;
      if (fro_a) n_fro++;
      if (fd_a) begin n_fd++; t_last = i; end
      if (rv_a) begin
        if (n_rv < 2) begin rv_val[n_rv] = res_a; rv_idx[n_rv] = idx_a; t_rv[n_rv] = i; end
        n_rv++;
      end
      if (done_a) begin n_done++; t_done = i; end
      if (i > 0 && !busy_a) t_idle = i;
    end
    start_a = 1'b0;
    stall_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (busy_a || done_a || rv_a) n_late++;
    end
    checks++;
    if (t_idle < 0) begin errors++; $display("FAIL pass_timeout: busy never dropped"); end
  endtask

  task automatic check_results_a(input string tag);
    checks++;
    if (rv_val[0] !== 16'h0500) begin
      errors++; $display("FAIL %s row0: got %h expected 0500", tag, rv_val[0]);
    end
    checks++;
    if (rv_val[1] !== 16'h0080) begin
      errors++; $display("FAIL %s row1: got %h expected 0080", tag, rv_val[1]);
    end
    checks++;
    if ({rv_idx[0], rv_idx[1]} !== 2'b01) begin
      errors++; $display("FAIL %s row_index: got %b expected 01", tag, {rv_idx[0], rv_idx[1]});
    end
    checks++;
    if (n_rv !== 2 || n_done !== 1 || n_fro !== 2 || n_fd !== 1 || n_fe !== 4) begin
      errors++;
      $display("FAIL %s counts: rv=%0d done=%0d fro=%0d fd=%0d fe=%0d expected 2 1 2 1 4",
               tag, n_rv, n_done, n_fro, n_fd, n_fe);
    end
    checks++;
    if (n_late !== 0) begin
      errors++; $display("FAIL %s idle_after: got %0d active cycles expected 0", tag, n_late);
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0; stall_a = 1'b0; stall_b = 1'b0;
    b_mat_val = '0; b_vec_val = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({init_a, fe_a, fro_a, fd_a, res_a, idx_a, rv_a, busy_a, done_a} !== '0) begin
      errors++; $display("FAIL reset_a: got busy=%b res=%h expected all zero", busy_a, res_a);
    end
    checks++;
    if ({init_b, fe_b, fro_b, fd_b, res_b, idx_b, rv_b, busy_b, done_b} !== '0) begin
      errors++; $display("FAIL reset_b: got busy=%b res=%h expected all zero", busy_b, res_b);
    end
    @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1;
  endtask

  task automatic test_basic();
    run_pass_a(1'b0, -1);
    check_results_a("basic");
    checks++;
    if (t_init !== 1 || t_last !== 5) begin
      errors++; $display("FAIL basic_issue_time: got init=%0d last=%0d expected 1 5", t_init, t_last);
    end
    checks++;
    if (t_rv[0] !== 5 || t_rv[1] !== 7) begin
      errors++; $display("FAIL basic_rv_time: got %0d %0d expected 5 7", t_rv[0], t_rv[1]);
    end
    checks++;
    if (t_done !== 8 || t_idle !== 9) begin
      errors++; $display("FAIL basic_done_time: got done=%0d idle=%0d expected 8 9", t_done, t_idle);
    end
  endtask

  task automatic test_stall();
    run_pass_a(1'b1, -1);
    check_results_a("stall");
    checks++;
    if (n_viol !== 0) begin
      errors++; $display("FAIL stall_violation: got %0d issues under stall expected 0", n_viol);
    end
    checks++;
    if (t_last !== 8 || t_rv[1] !== 10 || t_done !== 11) begin
      errors++;
      $display("FAIL stall_timing: got last=%0d rv=%0d done=%0d expected 8 10 11",
               t_last, t_rv[1], t_done);
    end
  endtask

  task automatic test_start_ignored();
    run_pass_a(1'b0, 3);
    check_results_a("start_busy");
    checks++;
    if (t_done !== 8) begin
      errors++; $display("FAIL start_busy_done: got %0d expected 8", t_done);
    end
  endtask

  task automatic test_abort();
    int abort_at;
    int n_bad;
    abort_at = -1;
    n_bad = 0;
    n_fe = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start_a = (i == 0);
      rst_a   = !(i == abort_at);
      #1;
      if (fe_a) n_fe++;
      if (n_fe == 3 && abort_at < 0) abort_at = i + 1;
      if (abort_at >= 0 && i == abort_at + 1) begin
        checks++;
        if ({init_a, fe_a, fro_a, fd_a, res_a, idx_a, rv_a, busy_a, done_a} !== '0) begin
          errors++; $display("FAIL abort_outputs: got busy=%b res=%h expected all zero",
                             busy_a, res_a);
        end
      end
      if (abort_at >= 0 && i > abort_at && (rv_a || done_a || busy_a)) n_bad++;
    end
    rst_a = 1'b1;
    checks++;
    if (abort_at !== 5) begin
      errors++; $display("FAIL abort_point: got %0d expected 5", abort_at);
    end
    checks++;
    if (n_bad !== 0) begin
      errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", n_bad);
    end
    run_pass_a(1'b0, -1);
    check_results_a("after_abort");
  endtask

  task automatic run_b(input logic [15:0] m, input logic [15:0] v, input logic [15:0] exp_res,
                       input string tag);
    logic [15:0] got;
    int          t_r, t_d;
    got = 'x; t_r = -1; t_d = -1; n_both = 0; n_fro = 0;
    b_mat_val = m;
    b_vec_val = v;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      start_b = (i == 0);
      #1;
      if (fro_b) n_fro++;
      if (fro_b && fd_b && fe_b) n_both++;
      if (rv_b) begin got = res_b; t_r = i; end
      if (done_b) t_d = i;
    end
    start_b = 1'b0;
    checks++;
    if (got !== exp_res) begin
      errors++; $display("FAIL %s result: got %h expected %h", tag, got, exp_res);
    end
    checks++;
    if (n_both !== 1 || n_fro !== 1 || t_r !== 4 || t_d !== 5) begin
      errors++;
      $display("FAIL %s control: got both=%0d fro=%0d rv_t=%0d done_t=%0d expected 1 1 4 5",
               tag, n_both, n_fro, t_r, t_d);
    end
  endtask

  task automatic test_saturation();
    run_b(16'h7F00, 16'h7F00, 16'h7FFF, "sat_pos");
    run_b(16'h8000, 16'h7F00, 16'h8000, "sat_neg");
    run_b(16'hFF00, 16'h0180, 16'hFE80, "neg_plain");
    run_b(16'hFFFF, 16'h0080, 16'hFFFF, "trunc_floor");
  endtask

  initial begin
    a_mat_mem[0] = 16'h0100; a_mat_mem[1] = 16'h0200;
    a_mat_mem[2] = 16'h0080; a_mat_mem[3] = 16'hFF00;
    a_vec_mem[0] = 16'h0300; a_vec_mem[1] = 16'h0100;
    test_reset();
    test_basic();
    test_stall();
    test_start_ignored();
    test_abort();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
